sbn_dmem_arbiter: RTL and testbench

- Shares the single-port SBN data memory between two requesters: the SBN core (port C) and a host loader/debug port (port H).
- Arbitration is round-robin on each cycle.
- A requester may lock the memory, so that an SBN read-A / read-B / write-C sequence completes atomically.
- A lock watchdog releases any lock that is held too long.
- The block sits between the core datapath, the host interface and the dmem array, which has a 1-cycle read latency.

---
 rtl/sbn_pkg.sv | 21 ++
 rtl/sbn_lock_watchdog.sv | 69 ++++++
 rtl/sbn_dmem_arbiter.sv | 151 +++++++++++++++
 tb/tb_sbn_dmem_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sbn_pkg.sv
// rtl/sbn_pkg.sv - shared constants for the SBN data-memory arbiter
package sbn_pkg;

    // Arbiter FSM encodings
    localparam logic [1:0] FREE   = 2'b00;
    localparam logic [1:0] LOCK_C = 2'b01;
    localparam logic [1:0] LOCK_H = 2'b10;

    // Requester identifiers, also used as round-robin pointer values
    typedef logic port_id_t;
    localparam port_id_t PORT_C = 1'b0;
    localparam port_id_t PORT_H = 1'b1;

    localparam int FWIDTH_DEF = 8;
    localparam int DWIDTH_DEF = 32;

    function automatic port_id_t other_port(input port_id_t p);
        return ~p;
    endfunction

endpackage

// File: rtl/sbn_lock_watchdog.sv
// rtl/sbn_lock_watchdog.sv - lock hold counter, forced release and relock blocking
module sbn_lock_watchdog
    import sbn_pkg::*;
#(
    parameter int lock_max = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     locked,
    input  port_id_t owner,
    input  logic     owner_lock,
    input  logic     start,
    input  logic     c_lock,
    input  logic     h_lock,
    output logic     expire,
    output logic     lock_err,
    output logic     c_blocked,
    output logic     h_blocked
);

    localparam logic [7:0] LIMIT = 8'(lock_max);

    logic [7:0] count;

    // The owner has used its whole budget and still wants the lock
    assign expire = locked & owner_lock & (count == LIMIT);

    // Count cycles of a held lock; a fresh lock starts at 1, anything else clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (start) begin
            count <= 8'd1;
        end else if (locked && owner_lock && !expire) begin
            count <= (count == LIMIT) ? count : count + 8'd1;
        end else begin
            count <= 8'd0;
        end
    end

    // One-cycle error pulse in the cycle after a forced release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_err <= 1'b0;
        end else begin
            lock_err <= expire;
        end
    end

    // A port whose lock was broken may not re-lock until it lets go of lock once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_blocked <= 1'b0;
            h_blocked <= 1'b0;
        end else begin
            if (expire && owner == PORT_C) begin
                c_blocked <= 1'b1;
            end else if (!c_lock) begin
                c_blocked <= 1'b0;
            end
            if (expire && owner == PORT_H) begin
                h_blocked <= 1'b1;
            end else if (!h_lock) begin
                h_blocked <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sbn_dmem_arbiter.sv
// rtl/sbn_dmem_arbiter.sv - round-robin, lockable arbiter for the SBN data memory
module sbn_dmem_arbiter
    import sbn_pkg::*;
#(
    parameter int fwidth   = FWIDTH_DEF,
    parameter int dwidth   = DWIDTH_DEF,
    parameter int lock_max = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c_req,
    input  logic              c_we,
    input  logic              c_lock,
    input  logic [fwidth-1:0] c_addr,
    input  logic [dwidth-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_rvalid,
    output logic [dwidth-1:0] c_rdata,
    input  logic              h_req,
    input  logic              h_we,
    input  logic              h_lock,
    input  logic [fwidth-1:0] h_addr,
    input  logic [dwidth-1:0] h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [dwidth-1:0] h_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [fwidth-1:0] mem_addr,
    output logic [dwidth-1:0] mem_wdata,
    input  logic [dwidth-1:0] mem_rdata,
    output logic              lock_err
);

    logic [1:0]  state;
    logic [1:0]  state_next;
    port_id_t    rr_ptr;
    port_id_t    ptr_next;
    port_id_t    owner;
    logic        locked;
    logic        owner_lock;
    logic        gnt_c;
    logic        gnt_h;
    logic        start;
    logic        expire;
    logic        c_blocked;
    logic        h_blocked;
    logic [dwidth-1:0] c_hold;
    logic [dwidth-1:0] h_hold;

    assign locked     = (state != FREE);
    assign owner      = (state == LOCK_H) ? PORT_H : PORT_C;
    assign owner_lock = (owner == PORT_H) ? h_lock : c_lock;

    sbn_lock_watchdog #(
        .lock_max (lock_max)
    ) u_watchdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .locked     (locked),
        .owner      (owner),
        .owner_lock (owner_lock),
        .start      (start),
        .c_lock     (c_lock),
        .h_lock     (h_lock),
        .expire     (expire),
        .lock_err   (lock_err),
        .c_blocked  (c_blocked),
        .h_blocked  (h_blocked)
    );

    // Grant decision: expiry beats everything, a held lock serves only its owner,
    // otherwise (including the cycle the owner drops lock) arbitrate round-robin
    always_comb begin
        gnt_c      = 1'b0;
        gnt_h      = 1'b0;
        state_next = state;
        ptr_next   = rr_ptr;
        start      = 1'b0;
        if (expire) begin
            state_next = FREE;
            ptr_next   = other_port(owner);
        end else if (locked && owner_lock) begin
            gnt_c = (owner == PORT_C) && c_req;
            gnt_h = (owner == PORT_H) && h_req;
        end else begin
            state_next = FREE;
            if (c_req && (!h_req || rr_ptr == PORT_C)) begin
                gnt_c = 1'b1;
            end else if (h_req) begin
                gnt_h = 1'b1;
            end
            if (gnt_c) begin
                ptr_next = PORT_H;
                if (c_lock && !c_blocked) begin
                    state_next = LOCK_C;
                    start      = 1'b1;
                end
            end else if (gnt_h) begin
                ptr_next = PORT_C;
                if (h_lock && !h_blocked) begin
                    state_next = LOCK_H;
                    start      = 1'b1;
                end
            end
        end
    end

    // Grants and memory strobes stay quiet while reset is asserted
    assign c_gnt     = gnt_c & rst_n;
    assign h_gnt     = gnt_h & rst_n;
    assign mem_en    = c_gnt | h_gnt;
    assign mem_we    = h_gnt ? h_we : (c_gnt & c_we);
    assign mem_addr  = h_gnt ? h_addr : c_addr;
    assign mem_wdata = h_gnt ? h_wdata : c_wdata;

    // FSM state and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FREE;
            rr_ptr <= PORT_C;
        end else begin
            state  <= state_next;
            rr_ptr <= ptr_next;
        end
    end

    // Read responses: valid the cycle after a read grant, data held until the next read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_rvalid <= 1'b0;
            h_rvalid <= 1'b0;
            c_hold   <= '0;
            h_hold   <= '0;
        end else begin
            c_rvalid <= c_gnt & ~c_we;
            h_rvalid <= h_gnt & ~h_we;
            if (c_rvalid) begin
                c_hold <= mem_rdata;
            end
            if (h_rvalid) begin
                h_hold <= mem_rdata;
            end
        end
    end

    // The memory delivers data in the rvalid cycle; afterwards the captured copy is shown
    assign c_rdata = c_rvalid ? mem_rdata : c_hold;
    assign h_rdata = h_rvalid ? mem_rdata : h_hold;

endmodule

// File: tb/tb_sbn_dmem_arbiter.sv
// tb/tb_sbn_dmem_arbiter.sv - scoreboard bench for sbn_dmem_arbiter
module tb_sbn_dmem_arbiter;

    localparam int LOCK_MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        c_req, c_we, c_lock, h_req, h_we, h_lock;
    logic [7:0]  c_addr, h_addr;
    logic [31:0] c_wdata, h_wdata;
    logic        c_gnt, c_rvalid, h_gnt, h_rvalid;
    logic [31:0] c_rdata, h_rdata;
    logic        mem_en, mem_we, lock_err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    sbn_dmem_arbiter #(
        .fwidth   (8),
        .dwidth   (32),
        .lock_max (LOCK_MAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .c_req     (c_req),
        .c_we      (c_we),
        .c_lock    (c_lock),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_gnt     (c_gnt),
        .c_rvalid  (c_rvalid),
        .c_rdata   (c_rdata),
        .h_req     (h_req),
        .h_we      (h_we),
        .h_lock    (h_lock),
        .h_addr    (h_addr),
        .h_wdata   (h_wdata),
        .h_gnt     (h_gnt),
        .h_rvalid  (h_rvalid),
        .h_rdata   (h_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .lock_err  (lock_err)
    );

    always #5 clk = ~clk;

    // Physical memory with one-cycle read latency
    logic [31:0] phys_mem [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) phys_mem[mem_addr] = mem_wdata;
            else        mem_rdata <= phys_mem[mem_addr];
        end
    end

    typedef struct packed {
        logic        gc, gh, lerr, rvc, rvh, men, mwe;
        logic [7:0]  maddr;
        logic [31:0] mwd, rdc, rdh;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    // Reference model: owner -1 means nobody holds the lock
    logic [31:0] ref_mem [256];
    int          owner, held, turn, mg;
    bit          blk[2], pend[2], lerr_pend;
    logic [31:0] pdat[2], hold[2];

    // Requester state
    bit          p_req[2], p_we[2], p_lock[2];
    logic [7:0]  p_addr[2];
    logic [31:0] p_wdata[2];
    int          lk_rem[2];

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic set_port(input int p, input bit req, input bit we, input bit lk,
                            input logic [7:0] addr, input logic [31:0] wd);
        p_req[p] = req; p_we[p] = we; p_lock[p] = lk; p_addr[p] = addr; p_wdata[p] = wd;
    endtask

    // Drive this cycle's inputs, predict the DUT's behaviour and queue the expectation
    task automatic apply();
        exp_t e;
        int   g;
        bit   lerr_next;
        c_req = p_req[0]; c_we = p_we[0]; c_lock = p_lock[0]; c_addr = p_addr[0]; c_wdata = p_wdata[0];
        h_req = p_req[1]; h_we = p_we[1]; h_lock = p_lock[1]; h_addr = p_addr[1]; h_wdata = p_wdata[1];
        e = '0;
        g = -1;
        lerr_next = 0;
        if (!rst_n) begin
            owner = -1; held = 0; turn = 0; lerr_pend = 0;
            for (int p = 0; p < 2; p++) begin
                blk[p] = 0; pend[p] = 0; hold[p] = '0; pdat[p] = '0;
            end
        end else begin
            e.rvc = pend[0]; e.rdc = pend[0] ? pdat[0] : hold[0];
            e.rvh = pend[1]; e.rdh = pend[1] ? pdat[1] : hold[1];
            e.lerr = lerr_pend;
            if (owner >= 0 && p_lock[owner] && held == LOCK_MAX) begin
                turn = 1 - owner;
                blk[owner] = 1;
                owner = -1;
                held = 0;
                lerr_next = 1;
            end else if (owner >= 0 && p_lock[owner]) begin
                if (p_req[owner]) g = owner;
                held++;
            end else begin
                owner = -1;
                held = 0;
                if (p_req[0] && p_req[1]) g = turn;
                else if (p_req[0])        g = 0;
                else if (p_req[1])        g = 1;
                if (g >= 0) begin
                    turn = 1 - g;
                    if (p_lock[g] && !blk[g]) begin
                        owner = g;
                        held = 1;
                    end
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (!p_lock[p]) blk[p] = 0;
                if (pend[p]) hold[p] = pdat[p];
                pend[p] = 0;
            end
            lerr_pend = lerr_next;
            if (g >= 0) begin
                e.gc = (g == 0); e.gh = (g == 1);
                e.men = 1; e.mwe = p_we[g]; e.maddr = p_addr[g]; e.mwd = p_wdata[g];
                if (p_we[g]) ref_mem[p_addr[g]] = p_wdata[g];
                else begin
                    pend[g] = 1;
                    pdat[g] = ref_mem[p_addr[g]];
                end
            end
        end
        mg = g;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        apply();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic gen(input int p);
        if (lk_rem[p] == 0 && $urandom_range(0, 5) == 0) lk_rem[p] = $urandom_range(2, 7);
        p_lock[p]  = (lk_rem[p] != 0);
        p_req[p]   = ($urandom_range(0, 3) != 0);
        p_we[p]    = 1'($urandom_range(0, 1));
        p_addr[p]  = 8'($urandom_range(0, 15));
        p_wdata[p] = $urandom;
    endtask

    // Monitor: compare every cycle against the queued expectation
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk_b("c_gnt", c_gnt, mon_e.gc);
            chk_b("h_gnt", h_gnt, mon_e.gh);
            chk_b("lock_err", lock_err, mon_e.lerr);
            chk_b("c_rvalid", c_rvalid, mon_e.rvc);
            chk_b("h_rvalid", h_rvalid, mon_e.rvh);
            chk_b("mem_en", mem_en, mon_e.men);
            chk_w("c_rdata", c_rdata, mon_e.rdc);
            chk_w("h_rdata", h_rdata, mon_e.rdh);
            if (mon_e.men) begin
                chk_b("mem_we", mem_we, mon_e.mwe);
                chk_w("mem_addr", 32'(mem_addr), 32'(mon_e.maddr));
                if (mon_e.mwe) chk_w("mem_wdata", mem_wdata, mon_e.mwd);
            end
        end
    end

    initial begin
        logic [7:0] wd_c, wd_h, wd_e;
        for (int i = 0; i < 256; i++) begin
            phys_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
            ref_mem[i]  = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
        end
        phys_mem[5] = 32'h0000_002A;
        ref_mem[5]  = 32'h0000_002A;
        for (int p = 0; p < 2; p++) begin
            set_port(p, 0, 0, 0, 8'h00, 32'h0);
            lk_rem[p] = 0;
        end

        @(posedge clk);
        #1;
        apply(); tick();
        apply(); tick();
        rst_n = 1'b1;

        // Contention straight after reset: C, H, C, H
        set_port(0, 1, 0, 0, 8'h01, 32'h0);
        set_port(1, 1, 0, 0, 8'h01, 32'h0);
        for (int i = 0; i < 4; i++) begin
            apply(); #1;
            chk_b("contend_c_gnt", c_gnt, (i % 2) == 0);
            chk_b("contend_h_gnt", h_gnt, (i % 2) == 1);
            tick();
        end
        set_port(1, 0, 0, 0, 8'h00, 32'h0);

        // Single core read of address 5
        set_port(0, 1, 0, 0, 8'h05, 32'h0);
        apply(); #1;
        chk_b("rd_c_gnt", c_gnt, 1'b1);
        chk_w("rd_mem_addr", 32'(mem_addr), 32'h05);
        chk_b("rd_h_gnt", h_gnt, 1'b0);
        tick();
        set_port(0, 0, 0, 0, 8'h00, 32'h0);
        apply(); #1;
        chk_b("rd_c_rvalid", c_rvalid, 1'b1);
        chk_w("rd_c_rdata", c_rdata, 32'h0000_002A);
        tick();

        // Atomic read-A / read-B / write-C while the host waits
        do_reset();
        set_port(1, 1, 0, 0, 8'h20, 32'h0);
        set_port(0, 1, 0, 1, 8'h10, 32'h0);
        apply(); #1; chk_b("atom0_h_gnt", h_gnt, 1'b0); chk_b("atom0_c_gnt", c_gnt, 1'b1); tick();
        set_port(0, 1, 0, 1, 8'h11, 32'h0);
        apply(); #1; chk_b("atom1_h_gnt", h_gnt, 1'b0); chk_b("atom1_c_gnt", c_gnt, 1'b1); tick();
        set_port(0, 1, 1, 1, 8'h12, 32'hFFFF_FFFF);
        apply(); #1; chk_b("atom2_h_gnt", h_gnt, 1'b0); chk_b("atom2_c_gnt", c_gnt, 1'b1); tick();
        set_port(0, 0, 0, 0, 8'h00, 32'h0);
        apply(); #1; chk_b("atom3_h_gnt", h_gnt, 1'b1); tick();
        set_port(1, 0, 0, 0, 8'h00, 32'h0);

        // Watchdog: core never lets go of lock
        do_reset();
        wd_c = 8'b0100_1111;
        wd_h = 8'b1010_0000;
        wd_e = 8'b0010_0000;
        set_port(0, 1, 0, 1, 8'h03, 32'h0);
        set_port(1, 1, 0, 0, 8'h04, 32'h0);
        for (int i = 0; i < 8; i++) begin
            apply(); #1;
            chk_b("wd_c_gnt", c_gnt, wd_c[i]);
            chk_b("wd_h_gnt", h_gnt, wd_h[i]);
            chk_b("wd_lock_err", lock_err, wd_e[i]);
            tick();
        end
        set_port(0, 0, 0, 0, 8'h00, 32'h0);
        set_port(1, 0, 0, 0, 8'h00, 32'h0);
        apply(); tick();

        // Reset in the cycle after a host read grant
        set_port(1, 1, 0, 0, 8'h07, 32'h0);
        apply(); #1; chk_b("mid_h_gnt", h_gnt, 1'b1); tick();
        rst_n = 1'b0;
        apply(); #1;
        chk_b("mid_h_rvalid", h_rvalid, 1'b0);
        chk_w("mid_h_rdata", h_rdata, 32'h0);
        tick();
        rst_n = 1'b1;
        set_port(1, 1, 0, 0, 8'h08, 32'h0);
        apply(); #1; chk_b("post_rst_h_gnt", h_gnt, 1'b1); tick();
        set_port(1, 0, 0, 0, 8'h00, 32'h0);

        // Host write of 0xFF then core read of the same word
        set_port(0, 1, 0, 0, 8'h09, 32'h0);
        apply(); tick();
        set_port(1, 1, 1, 0, 8'hFF, 32'h0000_0007);
        set_port(0, 1, 0, 0, 8'hFF, 32'h0);
        apply(); #1; chk_b("raw_h_gnt", h_gnt, 1'b1); chk_b("raw_c_wait", c_gnt, 1'b0); tick();
        set_port(1, 0, 0, 0, 8'h00, 32'h0);
        apply(); #1; chk_b("raw_c_gnt", c_gnt, 1'b1); tick();
        set_port(0, 0, 0, 0, 8'h00, 32'h0);
        apply(); #1;
        chk_b("raw_c_rvalid", c_rvalid, 1'b1);
        chk_w("raw_c_rdata", c_rdata, 32'h0000_0007);
        tick();

        // Randomized traffic with lock bursts long enough to trip the watchdog
        for (int p = 0; p < 2; p++) begin
            lk_rem[p] = 0;
            gen(p);
        end
        for (int n = 0; n < 3000; n++) begin
            apply();
            tick();
            for (int p = 0; p < 2; p++) begin
                if (mg == p || !p_req[p]) begin
                    if (mg == p && lk_rem[p] > 0) lk_rem[p]--;
                    gen(p);
                end
            end
        end

        for (int p = 0; p < 2; p++) set_port(p, 0, 0, 0, 8'h00, 32'h0);
        repeat (4) begin
            apply();
            tick();
        end
        @(negedge clk);
        #1;
        chk_w("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
